time_editor: RTL

//   Button-driven date/time editor, parametrised successor of set_time. Conditions the five buttons

---
 rtl/time_editor.sv | 326 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/time_editor.sv
// time_editor: five-button date/time editor. Debounces and auto-repeats the buttons, loads the live
// time, edits one field at a time with calendar-aware wrapping, and commits with a one-cycle pulse.
module time_editor #(
  parameter int unsigned DEBOUNCE_CYC     = 1_000_000,
  parameter int unsigned REPEAT_DELAY_CYC = 25_000_000,
  parameter int unsigned REPEAT_RATE_CYC  = 5_000_000,
  parameter int unsigned BLINK_CYC        = 12_500_000,
  parameter logic [3:0]  EDIT_MODE        = 4'd1,
  parameter int unsigned YEAR_MIN         = 2000,
  parameter int unsigned YEAR_MAX         = 2099
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mode,
  input  logic        button_mid,
  input  logic        button_l,
  input  logic        button_r,
  input  logic        button_up,
  input  logic        button_down,
  input  logic [15:0] cur_year,
  input  logic [7:0]  cur_month,
  input  logic [7:0]  cur_day,
  input  logic [7:0]  cur_hour,
  input  logic [7:0]  cur_minute,
  input  logic [7:0]  cur_sec,
  output logic [15:0] year,
  output logic [7:0]  month,
  output logic [7:0]  day,
  output logic [7:0]  hour,
  output logic [7:0]  minute,
  output logic [7:0]  sec,
  output logic [3:0]  week,
  output logic [2:0]  field_sel,
  output logic        editing,
  output logic        commit,
  output logic        blink
);

  localparam int unsigned RP_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC
                                                                       : REPEAT_RATE_CYC;
  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int RP_W = $clog2(RP_MAX + 1);
  localparam int BL_W = $clog2(BLINK_CYC + 1);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [RP_W-1:0] RP_DELAY  = RP_W'(REPEAT_DELAY_CYC);
  localparam logic [RP_W-1:0] RP_RATE   = RP_W'(REPEAT_RATE_CYC);
  localparam logic [BL_W-1:0] BL_LAST   = BL_W'(BLINK_CYC - 1);
  localparam logic [11:0]     Y_MIN     = 12'(YEAR_MIN);
  localparam logic [11:0]     Y_MAX     = 12'(YEAR_MAX);

  localparam int B_MID = 0;
  localparam int B_L   = 1;
  localparam int B_R   = 2;
  localparam int B_UP  = 3;
  localparam int B_DN  = 4;

  localparam logic [2:0] F_YEAR  = 3'd0;
  localparam logic [2:0] F_MONTH = 3'd1;
  localparam logic [2:0] F_DAY   = 3'd2;
  localparam logic [2:0] F_HOUR  = 3'd3;
  localparam logic [2:0] F_MIN   = 3'd4;
  localparam logic [2:0] F_SEC   = 3'd5;

  typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

  // ---------------------------------------------------------------- helper functions
  function automatic logic [5:0] load2(input logic [7:0] b, input logic [5:0] lo,
                                       input logic [5:0] hi);
    logic [6:0] v;
    v = 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
    if (b[7:4] > 4'd9 || b[3:0] > 4'd9 || v < 7'(lo) || v > 7'(hi)) return lo;
    return 6'(v);
  endfunction

  function automatic logic [11:0] load_year(input logic [15:0] b);
    logic [13:0] v;
    v = 14'(b[15:12]) * 14'd1000 + 14'(b[11:8]) * 14'd100 + 14'(b[7:4]) * 14'd10 + 14'(b[3:0]);
    if (b[15:12] > 4'd9 || b[11:8] > 4'd9 || b[7:4] > 4'd9 || b[3:0] > 4'd9 ||
        v < 14'(YEAR_MIN) || v > 14'(YEAR_MAX)) return Y_MIN;
    return 12'(v);
  endfunction

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  // Years are confined to 1901..2099, so the century digits are always 19 or 20.
  function automatic logic [15:0] year_bcd(input logic [11:0] y);
    logic [11:0] rem;
    rem = (y >= 12'd2000) ? y - 12'd2000 : y - 12'd1900;
    return {(y >= 12'd2000) ? 8'h20 : 8'h19, to_bcd(7'(rem))};
  endfunction

  function automatic logic [5:0] dim(input logic [1:0] y_lo, input logic [5:0] mo);
    case (mo)
      6'd2:                     return (y_lo == 2'd0) ? 6'd29 : 6'd28;
      6'd4, 6'd6, 6'd9, 6'd11:  return 6'd30;
      default:                  return 6'd31;
    endcase
  endfunction

  // Sakamoto's method; y/100 and y/400 collapse to constants inside 1900..2099.
  function automatic logic [3:0] weekday(input logic [11:0] y, input logic [5:0] mo,
                                         input logic [5:0] d);
    logic [11:0] yy;
    logic [2:0]  t;
    logic [12:0] sum;
    logic [2:0]  r;
    yy = (mo < 6'd3) ? y - 12'd1 : y;
    case (mo)
      6'd2, 6'd6:   t = 3'd3;
      6'd3, 6'd11:  t = 3'd2;
      6'd4, 6'd7:   t = 3'd5;
      6'd8:         t = 3'd1;
      6'd9, 6'd12:  t = 3'd4;
      6'd10:        t = 3'd6;
      default:      t = 3'd0;
    endcase
    sum = 13'(yy) + 13'(yy[11:2]) - ((yy >= 12'd2000) ? 13'd20 : 13'd19)
        + ((yy >= 12'd2000) ? 13'd5 : 13'd4) + 13'(t) + 13'(d);
    r = 3'(sum % 13'd7);
    return (r == 3'd0) ? 4'd7 : {1'b0, r};
  endfunction

  // ---------------------------------------------------------------- button conditioning
  logic [4:0]      raw, sync1, sync2, db, db_q, press;
  logic [DB_W-1:0] db_cnt [5];
  logic [RP_W-1:0] rep_cnt [2];
  logic [1:0]      rep_fast, rep_evt;

  assign raw   = {button_down, button_up, button_r, button_l, button_mid};
  assign press = db & ~db_q;

  always_ff @(posedge clk) begin
    // NOTE: the debounce counters are a handful of flops, not a RAM, so resetting the array is fine.
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values, so order is irrelevant.
      sync1 <= raw;
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          db[i]     <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // rep_cnt counts cycles since the last press/repeat event; it is zero while released.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    rep_evt = '0;
    for (int j = 0; j < 2; j++)
      rep_evt[j] = db[B_UP+j] && !press[B_UP+j] &&
                   (rep_cnt[j] == (rep_fast[j] ? RP_RATE : RP_DELAY));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_fast <= '0;
      for (int j = 0; j < 2; j++) rep_cnt[j] <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (!db[B_UP+j]) begin
          rep_cnt[j]  <= '0;
          rep_fast[j] <= 1'b0;
        end else if (press[B_UP+j]) begin
          rep_cnt[j]  <= RP_W'(1);
          rep_fast[j] <= 1'b0;
        end else if (rep_evt[j]) begin
          rep_cnt[j]  <= RP_W'(1);
          rep_fast[j] <= 1'b1;
        end else begin
          rep_cnt[j]  <= rep_cnt[j] + 1'b1;
        end
      end
    end
  end

  logic ev_mid, ev_l, ev_r, ev_up, ev_dn;
  assign ev_mid = press[B_MID];
  assign ev_l   = press[B_L];
  assign ev_r   = press[B_R];
  assign ev_up  = press[B_UP] | rep_evt[0];
  assign ev_dn  = press[B_DN] | rep_evt[1];

  // ---------------------------------------------------------------- editor FSM
  state_t      state_q, state_d;
  logic [2:0]  sel_d;
  logic [11:0] y_q, y_d, ld_y;
  logic [5:0]  mo_q, d_q, h_q, mi_q, s_q;
  logic [5:0]  mo_d, d_d, h_d, mi_d, s_d;
  logic [5:0]  ld_mo, ld_d, ld_h, ld_mi, ld_s, dim_cur, dim_new;
  logic [BL_W-1:0] blink_cnt;

  assign ld_y    = load_year(cur_year);
  assign ld_mo   = load2(cur_month,  6'd1, 6'd12);
  assign ld_d    = load2(cur_day,    6'd1, 6'd31);
  assign ld_h    = load2(cur_hour,   6'd0, 6'd23);
  assign ld_mi   = load2(cur_minute, 6'd0, 6'd59);
  assign ld_s    = load2(cur_sec,    6'd0, 6'd59);
  assign dim_cur = dim(y_q[1:0], mo_q);

  always_comb begin
    state_d = state_q;
    sel_d   = field_sel;
    y_d     = y_q;
    mo_d    = mo_q;
    d_d     = d_q;
    h_d     = h_q;
    mi_d    = mi_q;
    s_d     = s_q;
    dim_new = dim_cur;
    case (state_q)
      IDLE: begin
        {y_d, mo_d, d_d, h_d, mi_d, s_d} = {ld_y, ld_mo, ld_d, ld_h, ld_mi, ld_s};
        if (ev_mid && mode == EDIT_MODE) begin
          state_d = EDIT;
          sel_d   = F_YEAR;
        end
      end
      EDIT: begin
        if (mode != EDIT_MODE) begin
          state_d = IDLE;
          {y_d, mo_d, d_d, h_d, mi_d, s_d} = {ld_y, ld_mo, ld_d, ld_h, ld_mi, ld_s};
        end else if (ev_mid) begin
          state_d = COMMIT;
        end else if (ev_l || ev_r) begin
          // Simultaneous left and right cancel each other.
          if (ev_l && !ev_r)      sel_d = (field_sel == F_YEAR) ? F_SEC : field_sel - 3'd1;
          else if (ev_r && !ev_l) sel_d = (field_sel == F_SEC) ? F_YEAR : field_sel + 3'd1;
        end else if (ev_up ^ ev_dn) begin
          case (field_sel)
            F_YEAR, F_MONTH: begin
              if (field_sel == F_YEAR)
                y_d = ev_up ? ((y_q >= Y_MAX) ? Y_MIN : y_q + 12'd1)
                            : ((y_q <= Y_MIN) ? Y_MAX : y_q - 12'd1);
              else
                mo_d = ev_up ? ((mo_q >= 6'd12) ? 6'd1 : mo_q + 6'd1)
                             : ((mo_q <= 6'd1) ? 6'd12 : mo_q - 6'd1);
              dim_new = dim(y_d[1:0], mo_d);
              if (d_q > dim_new) d_d = dim_new;
            end
            F_DAY:  d_d  = ev_up ? ((d_q >= dim_cur) ? 6'd1 : d_q + 6'd1)
                                 : ((d_q <= 6'd1) ? dim_cur : d_q - 6'd1);
            F_HOUR: h_d  = ev_up ? ((h_q >= 6'd23) ? 6'd0 : h_q + 6'd1)
                                 : ((h_q == 6'd0) ? 6'd23 : h_q - 6'd1);
            F_MIN:  mi_d = ev_up ? ((mi_q >= 6'd59) ? 6'd0 : mi_q + 6'd1)
                                 : ((mi_q == 6'd0) ? 6'd59 : mi_q - 6'd1);
            F_SEC:  s_d  = ev_up ? ((s_q >= 6'd59) ? 6'd0 : s_q + 6'd1)
                                 : ((s_q == 6'd0) ? 6'd59 : s_q - 6'd1);
            default: ;
          endcase
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      field_sel <= F_YEAR;
      y_q       <= 12'd2000;
      mo_q      <= 6'd1;
      d_q       <= 6'd1;
      h_q       <= 6'd0;
      mi_q      <= 6'd0;
      s_q       <= 6'd0;
      year      <= 16'h2000;
      month     <= 8'h01;
      day       <= 8'h01;
      hour      <= 8'h00;
      minute    <= 8'h00;
      sec       <= 8'h00;
      week      <= 4'd6;
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else begin
      state_q   <= state_d;
      field_sel <= sel_d;
      y_q       <= y_d;
      mo_q      <= mo_d;
      d_q       <= d_d;
      h_q       <= h_d;
      mi_q      <= mi_d;
      s_q       <= s_d;
      year      <= year_bcd(y_d);
      month     <= to_bcd({1'b0, mo_d});
      day       <= to_bcd({1'b0, d_d});
      hour      <= to_bcd({1'b0, h_d});
      minute    <= to_bcd({1'b0, mi_d});
      sec       <= to_bcd({1'b0, s_d});
      // Weekday follows the registered date, hence one cycle behind it.
      week      <= weekday(y_q, mo_q, d_q);
      if (state_d == EDIT) begin
        if (blink_cnt == BL_LAST) begin
          blink_cnt <= '0;
          blink     <= ~blink;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else begin
        blink_cnt <= '0;
        blink     <= 1'b0;
      end
    end
  end

  assign editing = (state_q == EDIT);
  assign commit  = (state_q == COMMIT);

endmodule
